// File: rtl/mobilenet_pkg.sv
// Types and constants shared by the MobileNet layer sequencers.
package mobilenet_pkg;

  localparam int ACC_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_START,
    S_WAIT,
    S_BIAS,
    S_OUTPUT,
    S_DONE
  } fc_seq_state_t;

endpackage

// File: rtl/chunk_mask.sv
// Per-lane enable for an input chunk: every lane is live except, on the last
// chunk, the lanes at or above the tail count.
module chunk_mask #(
  parameter int LANES = 10,
  parameter int CNT_W = 16
) (
  input  logic             last_chunk_i,
  input  logic [CNT_W-1:0] tail_i,
  output logic [LANES-1:0] mask_o
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign mask_o[gi] = !last_chunk_i || (CNT_W'(gi) < tail_i);
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Walks every neuron and input chunk of a fully-connected layer through the
// shared fc dot-product unit, then adds bias, optional ReLU and streams results.
module fc_layer_sequencer
  import mobilenet_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int OPS_PER_CYCLE = 10,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  cfg_start,
  input  logic [15:0]                           cfg_num_in,
  input  logic [15:0]                           cfg_num_out,
  input  logic                                  cfg_relu,
  output logic                                  busy,
  output logic                                  layer_done,
  output logic                                  op_rd_en,
  output logic [ADDR_WIDTH-1:0]                 op_rd_addr,
  input  logic [OPS_PER_CYCLE*DATA_WIDTH-1:0]   op_rd_data,
  output logic                                  wt_rd_en,
  output logic [ADDR_WIDTH-1:0]                 wt_rd_addr,
  input  logic [OPS_PER_CYCLE*DATA_WIDTH-1:0]   wt_rd_data,
  output logic                                  bias_rd_en,
  output logic [ADDR_WIDTH-1:0]                 bias_rd_addr,
  input  logic [DATA_WIDTH-1:0]                 bias_rd_data,
  output logic [OPS_PER_CYCLE*DATA_WIDTH-1:0]   fc_operands,
  output logic [OPS_PER_CYCLE*DATA_WIDTH-1:0]   fc_weights,
  output logic [OPS_PER_CYCLE*DATA_WIDTH-1:0]   fc_biases,
  output logic                                  fc_start,
  input  logic                                  fc_done,
  input  logic [ACC_WIDTH-1:0]                  fc_result,
  output logic [ACC_WIDTH-1:0]                  out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [15:0]                           out_index
);

  localparam int VEC_W = OPS_PER_CYCLE * DATA_WIDTH;

  fc_seq_state_t           state_q, state_d;
  logic [16:0]             chunks_q, chunks_d;
  logic [15:0]             tail_q, tail_d;
  logic [15:0]             num_out_q, num_out_d;
  logic [15:0]             chunk_q, chunk_d;
  logic [15:0]             neuron_q, neuron_d;
  logic                    relu_q, relu_d;
  logic [ADDR_WIDTH-1:0]   wt_addr_q, wt_addr_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [ACC_WIDTH-1:0]    bias_q, bias_d;
  logic [ACC_WIDTH-1:0]    out_data_q, out_data_d;
  logic [VEC_W-1:0]        fc_op_q, fc_op_d;
  logic [VEC_W-1:0]        fc_wt_q, fc_wt_d;

  logic [16:0]             chunks_calc;
  logic [15:0]             tail_calc;
  logic                    last_chunk;
  logic                    last_neuron;
  logic [OPS_PER_CYCLE-1:0] lane_mask;
  logic [VEC_W-1:0]        lane_bits;
  logic [ACC_WIDTH-1:0]    biased;

  // 17-bit sum so the round-up cannot overflow for num_in near 65535
  assign chunks_calc = ({1'b0, cfg_num_in} + 17'(OPS_PER_CYCLE - 1)) / 17'(OPS_PER_CYCLE);
  assign tail_calc   = cfg_num_in - 16'((chunks_calc - 17'd1) * 17'(OPS_PER_CYCLE));
  assign last_chunk  = ({1'b0, chunk_q} == chunks_q - 17'd1);
  assign last_neuron = (neuron_q == num_out_q - 16'd1);
  assign biased      = acc_q + bias_q;

  chunk_mask #(
    .LANES (OPS_PER_CYCLE),
    .CNT_W (16)
  ) u_chunk_mask (
    .last_chunk_i (last_chunk),
    .tail_i       (tail_q),
    .mask_o       (lane_mask)
  );

  for (genvar gi = 0; gi < OPS_PER_CYCLE; gi++) begin : g_lane_bits
    assign lane_bits[gi*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{lane_mask[gi]}};
  end

  always_comb begin
    state_d    = state_q;
    chunks_d   = chunks_q;
    tail_d     = tail_q;
    num_out_d  = num_out_q;
    chunk_d    = chunk_q;
    neuron_d   = neuron_q;
    relu_d     = relu_q;
    wt_addr_d  = wt_addr_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    fc_op_d    = fc_op_q;
    fc_wt_d    = fc_wt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          chunks_d  = chunks_calc;
          tail_d    = tail_calc;
          num_out_d = cfg_num_out;
          relu_d    = cfg_relu;
          chunk_d   = '0;
          neuron_d  = '0;
          wt_addr_d = '0;
          acc_d     = '0;
          state_d   = (cfg_num_in == 16'd0 || cfg_num_out == 16'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        wt_addr_d = wt_addr_q + 1'b1;
        state_d   = S_CAPTURE;
      end
      S_CAPTURE: begin
        fc_op_d = op_rd_data & lane_bits;
        fc_wt_d = wt_rd_data & lane_bits;
        // Bias is only fetched alongside chunk 0 of each neuron
        if (chunk_q == 16'd0)
          bias_d = {{(ACC_WIDTH-DATA_WIDTH){bias_rd_data[DATA_WIDTH-1]}}, bias_rd_data};
        state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (fc_done) begin
          acc_d = acc_q + fc_result;
          if (last_chunk) begin
            state_d = S_BIAS;
          end else begin
            chunk_d = chunk_q + 16'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_BIAS: begin
        out_data_d = (relu_q && biased[ACC_WIDTH-1]) ? '0 : biased;
        state_d    = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) begin
          acc_d   = '0;
          chunk_d = '0;
          if (last_neuron) begin
            state_d = S_DONE;
          end else begin
            neuron_d = neuron_q + 16'd1;
            state_d  = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      chunks_q   <= '0;
      tail_q     <= '0;
      num_out_q  <= '0;
      chunk_q    <= '0;
      neuron_q   <= '0;
      relu_q     <= 1'b0;
      wt_addr_q  <= '0;
      acc_q      <= '0;
      bias_q     <= '0;
      out_data_q <= '0;
      fc_op_q    <= '0;
      fc_wt_q    <= '0;
    end else begin
      state_q    <= state_d;
      chunks_q   <= chunks_d;
      tail_q     <= tail_d;
      num_out_q  <= num_out_d;
      chunk_q    <= chunk_d;
      neuron_q   <= neuron_d;
      relu_q     <= relu_d;
      wt_addr_q  <= wt_addr_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      out_data_q <= out_data_d;
      fc_op_q    <= fc_op_d;
      fc_wt_q    <= fc_wt_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign layer_done   = (state_q == S_DONE);
  assign op_rd_en     = (state_q == S_FETCH);
  assign wt_rd_en     = (state_q == S_FETCH);
  assign bias_rd_en   = (state_q == S_FETCH) && (chunk_q == 16'd0);
  assign op_rd_addr   = ADDR_WIDTH'(chunk_q);
  assign wt_rd_addr   = wt_addr_q;
  assign bias_rd_addr = ADDR_WIDTH'(neuron_q);
  assign fc_operands  = fc_op_q;
  assign fc_weights   = fc_wt_q;
  assign fc_biases    = '0;
  assign fc_start     = (state_q == S_START);
  assign out_valid    = (state_q == S_OUTPUT);
  assign out_data     = out_data_q;
  assign out_index    = neuron_q;

endmodule
